// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU.
// Imported by alu_core and alu_pipe.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, op) -> (res, flags).
// Define ALU_SAT_EN to saturate ADD/SUB on signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  output logic [WIDTH-1:0] o_res,
  output logic [3:0]       o_flags
);

  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic               w_add_v;
  logic               w_sub_v;
  logic               w_slt;
  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_sat;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};

  assign w_add_v = (i_a[WIDTH-1] == i_b[WIDTH-1])
                 & (w_add[WIDTH-1] != i_a[WIDTH-1]);
  assign w_sub_v = (i_a[WIDTH-1] != i_b[WIDTH-1])
                 & (w_sub[WIDTH-1] != i_a[WIDTH-1]);

  assign w_slt = $signed(i_a) < $signed(i_b);
  assign w_amt = i_b[SHW-1:0];

  // On overflow the sign of a tells which rail was crossed
  assign w_sat = i_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (i_op)
      ALU_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = w_add_v;
      end
      ALU_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = w_sub_v;
      end
      ALU_AND: w_res = i_a & i_b;
      ALU_OR:  w_res = i_a | i_b;
      ALU_XOR: w_res = i_a ^ i_b;
      ALU_SLL: w_res = i_a << w_amt;
      ALU_SRL: w_res = i_a >> w_amt;
      ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_res = '0;
    endcase
    if (SAT && w_v) w_res = w_sat;
  end

  always_comb begin
    o_res          = w_res;
    o_flags        = '0;
    o_flags[FLG_Z] = (w_res == '0);
    o_flags[FLG_N] = w_res[WIDTH-1];
    o_flags[FLG_C] = w_c;
    o_flags[FLG_V] = w_v;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// ALU_SAT_EN (optional) enables ADD/SUB saturation in alu_core.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  logic             r_s1_v;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  alu_op_e          r_s1_op;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_out;
  logic [3:0]       r_flags;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;

  // A stage moves when empty or when its content leaves this cycle
  assign w_s2_adv = !r_s2_v | out_ready;
  assign w_s1_adv = !r_s1_v | w_s2_adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .i_op    (r_s1_op),
    .o_res   (w_res),
    .o_flags (w_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v  <= 1'b0;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
      r_s1_op <= ALU_ADD;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_a  <= in1;
        r_s1_b  <= in2;
        r_s1_op <= alu_op_e'(sel);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v  <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_v;
  assign out       = r_out;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: WIDTH 8/16/32 instances share one stimulus stream
// and are scored against an integer-arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [2:0]  sel = '0;

  logic        rdy8, rdy16, rdy32;
  logic        ov8, ov16, ov32;
  logic [7:0]  out8;
  logic [15:0] out16;
  logic [31:0] out32;
  logic [3:0]  fl8, fl16, fl32;

  int n_vec = 0;
  int n_err = 0;

  logic [35:0] q [3][$];
  int          wd [3] = '{8, 16, 32};
  logic        rdy [3];
  logic        ovv [3];
  logic [31:0] oo [3];
  logic [3:0]  ff [3];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in1(in1[7:0]), .in2(in2[7:0]), .sel(sel), .out_valid(ov8),
    .out_ready(out_ready), .out(out8), .flags(fl8));

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .in1(in1[15:0]), .in2(in2[15:0]), .sel(sel), .out_valid(ov16),
    .out_ready(out_ready), .out(out16), .flags(fl16));

  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in1(in1), .in2(in2), .sel(sel), .out_valid(ov32),
    .out_ready(out_ready), .out(out32), .flags(fl32));

  assign rdy[0] = rdy8;  assign rdy[1] = rdy16; assign rdy[2] = rdy32;
  assign ovv[0] = ov8;   assign ovv[1] = ov16;  assign ovv[2] = ov32;
  assign oo[0] = {24'd0, out8};
  assign oo[1] = {16'd0, out16};
  assign oo[2] = out32;
  assign ff[0] = fl8;    assign ff[1] = fl16;   assign ff[2] = fl32;

  // Reference: returns {Z,N,C,V, result[31:0]} for width w
  function automatic logic [35:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] ai,
                                        input logic [31:0] bi);
    longint unsigned m, a, b, r, amt;
    longint sa, sb, s, hi, lo;
    logic c, v, z, n;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    a  = {32'd0, ai} & m;
    b  = {32'd0, bi} & m;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    sa = longint'(a);
    if (sa > hi) sa = sa - longint'(m) - 1;
    sb = longint'(b);
    if (sb > hi) sb = sb - longint'(m) - 1;
    sh = 0;
    while ((1 << sh) < w) sh++;
    amt = b & ((64'd1 << sh) - 64'd1);
    c = 1'b0; v = 1'b0; r = 0; s = 0;
    case (op)
      3'd0: begin
        s = sa + sb; r = (a + b) & m;
        c = ((a + b) >> w) != 0;
        v = (s > hi) || (s < lo);
      end
      3'd1: begin
        s = sa - sb; r = (a - b) & m;
        c = a < b;
        v = (s > hi) || (s < lo);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a << amt) & m;
      3'd6: r = a >> amt;
      default: r = (sa < sb) ? 1 : 0;
    endcase
`ifdef ALU_SAT_EN
    if (v) r = (s > hi) ? $unsigned(hi) : ($unsigned(lo) & m);
`endif
    z = (r == 0);
    n = ((r >> (w - 1)) & 1) != 0;
    return {z, n, c, v, r[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: check outputs, then record accepted inputs
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready_w%0d", wd[k]), 64'(rdy[k]),
            64'(q[k].size() < 2 || out_ready));
        if (q[k].size() == 0) begin
          chk($sformatf("idle_valid_w%0d", wd[k]), 64'(ovv[k]), 64'd0);
        end else if (ovv[k]) begin
          chk($sformatf("out_w%0d", wd[k]), 64'(oo[k]),
              64'(q[k][0][31:0]));
          chk($sformatf("flags_w%0d", wd[k]), 64'(ff[k]),
              64'(q[k][0][35:32]));
          if (out_ready) void'(q[k].pop_front());
        end
        if (in_valid && rdy[k])
          q[k].push_back(model(wd[k], sel, in1, in2));
      end
    end
  end

  function automatic logic [31:0] rnd_opd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_7FFF;
      3: return 32'h8000_8000;
      4: return 32'h7F7F_7F7F;
      5: return 32'h8080_8080;
      6: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_rand();
    sel = 3'($urandom_range(0, 7));
    in1 = rnd_opd();
    in2 = rnd_opd();
  endtask

  task automatic drain();
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    chk("drain_q8", 64'(q[0].size()), 64'd0);
    chk("drain_q16", 64'(q[1].size()), 64'd0);
    chk("drain_q32", 64'(q[2].size()), 64'd0);
  endtask

  task automatic dir(input string name, input logic [2:0] op,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eo, input logic [3:0] ef);
    chk({name, "_model"}, 64'(model(16, op, {16'd0, a}, {16'd0, b})),
        64'({ef, 16'd0, eo}));
    @(posedge clk); #1;
    in_valid = 1'b1; sel = op; in1 = {16'd0, a}; in2 = {16'd0, b};
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1"}, 64'(ov16), 64'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 64'(ov16), 64'd1);
    chk({name, "_out"}, 64'(out16), 64'(eo));
    chk({name, "_flags"}, 64'(ff[1]), 64'(ef));
  endtask

  initial begin
    int cnt, first, last;
    logic [15:0] held;

    #2;
    chk("rst_valid", 64'(ov16), 64'd0);
    chk("rst_out", 64'(out16), 64'd0);
    chk("rst_flags", 64'(fl16), 64'd0);
    chk("rst_ready", 64'(rdy16), 64'd1);
    #11 rst_n = 1'b1;
    out_ready = 1'b1;

`ifdef ALU_SAT_EN
    dir("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0001);
`else
    dir("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
`endif
    dir("sub_brw", 3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110);
    dir("slt_neg", 3'd7, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000);
    dir("sub_zero", 3'd1, 16'h0005, 16'h0005, 16'h0000, 4'b1000);
    dir("sll_mask", 3'd5, 16'h0001, 16'h0013, 16'h0008, 4'b0000);
    dir("srl_15", 3'd6, 16'h8000, 16'h000F, 16'h0001, 4'b0000);
    dir("xor", 3'd4, 16'hAAAA, 16'hFFFF, 16'h5555, 4'b0000);
    dir("sll_0", 3'd5, 16'h1234, 16'h0010, 16'h1234, 4'b0000);
    drain();

    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ov16) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      if (c < 8) begin
        in_valid = 1'b1;
        drive_rand();
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream_count", 64'(cnt), 64'd8);
    chk("stream_first", 64'(first), 64'd2);
    chk("stream_span", 64'(last - first), 64'd7);
    drain();

    held = '0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_rand();
    end
    out_ready = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      drive_rand();
      if (j == 1) held = out16;
      else begin
        chk("stall_out", 64'(out16), 64'(held));
        chk("stall_valid", 64'(ov16), 64'd1);
        chk("stall_ready", 64'(rdy16), 64'd0);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive_rand();
    end
    drain();

    @(posedge clk); #1;
    in_valid = 1'b1; drive_rand();
    @(posedge clk); #1;
    drive_rand();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_valid_w%0d", wd[k]), 64'(ovv[k]), 64'd0);
      chk($sformatf("arst_out_w%0d", wd[k]), 64'(oo[k]), 64'd0);
      chk($sformatf("arst_flags_w%0d", wd[k]), 64'(ff[k]), 64'd0);
      q[k].delete();
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(ov16), 64'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive_rand();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
